// File: rtl/uart_rx_frontend.sv
// uart_rx_frontend: oversampling 8N1 UART receiver with show-ahead byte FIFO; define UART_RX_PARITY_EN for 8E1 with parity_err
module uart_rx_frontend #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
`ifdef UART_RX_PARITY_EN
  output logic       parity_err,
`endif
  output logic       overrun_err
);
  localparam int DIV = (CLK_HZ + BAUD * OVERSAMPLE / 2) / (BAUD * OVERSAMPLE);
  localparam int CPT = DIV < 1 ? 1 : DIV;
  localparam int CW = $clog2(CPT + 1);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;
`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
`endif
  state_t state;
  logic rxd_m, rxd_s;
  logic [CW-1:0] cnt;
  logic [TW-1:0] ti;
  logic [2:0] bit_idx;
  logic [7:0] shreg;
  logic v0, v1, v2;
  logic push;
  logic tick, bit_end, vote, vote_now, hold;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count;
  logic pop, full, accept;
`ifdef UART_RX_PARITY_EN
  logic par_bad;
`endif
  // two-flop synchroniser on the asynchronous line, idling high
  always_ff @(posedge clk) {rxd_s, rxd_m} <= rst ? 2'b11 : {rxd_m, rxd_in};
  // tick strobes, bit votes and FIFO handshake decode
  always_comb begin
    hold = state == IDLE || state == WAIT_HIGH;
    tick = cnt == CW'(CPT - 1);
    bit_end = tick && ti == TW'(OVERSAMPLE - 1);
    vote = (v0 & v1) | (v0 & v2) | (v1 & v2);
    vote_now = (v0 & v1) | (v0 & rxd_s) | (v1 & rxd_s);
    rx_valid = count != '0;
    rx_data = mem[rd_ptr];
    pop = rx_valid && rx_ready;
    full = count[AW];
    accept = push && (!full || pop);
  end
  // receive state machine: tick timing, mid-bit voting, framing and byte hand-off
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      ti <= '0;
      bit_idx <= '0;
      shreg <= '0;
      {v0, v1, v2} <= 3'b111;
      push <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      push <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      cnt <= (hold || tick) ? '0 : cnt + CW'(1);
      if (hold) ti <= '0;
      else if (tick) ti <= bit_end ? '0 : ti + TW'(1);
      if (tick && ti == TW'(OVERSAMPLE / 2 - 1)) v0 <= rxd_s;
      if (tick && ti == TW'(OVERSAMPLE / 2)) v1 <= rxd_s;
      if (tick && ti == TW'(OVERSAMPLE / 2 + 1)) v2 <= rxd_s;
      case (state)
        IDLE: if (!rxd_s) state <= START;
        START: if (bit_end) begin
          state <= vote ? IDLE : DATA;
          bit_idx <= '0;
        end
        DATA: if (bit_end) begin
          shreg <= {vote, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == 3'd7) state <= PARITY;
`else
          if (bit_idx == 3'd7) state <= STOP;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (bit_end) begin
          par_bad <= vote ^ (^shreg);
          state <= STOP;
        end
        STOP: if (tick && ti == TW'(OVERSAMPLE / 2 + 1)) begin
          push <= vote_now && !par_bad;
          frame_err <= !vote_now;
          parity_err <= par_bad;
          state <= vote_now ? IDLE : WAIT_HIGH;
        end
`else
        STOP: if (tick && ti == TW'(OVERSAMPLE / 2 + 1)) begin
          push <= vote_now;
          frame_err <= !vote_now;
          state <= vote_now ? IDLE : WAIT_HIGH;
        end
`endif
        WAIT_HIGH: if (rxd_s) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
  // show-ahead byte FIFO; a full FIFO still takes a byte when the head leaves in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overrun_err <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= shreg;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + NW'(accept) - NW'(pop);
      overrun_err <= push && full && !pop;
    end
  end
endmodule

// File: tb/tb_uart_rx_frontend.sv
// tb_uart_rx_frontend: table-driven frames plus scoreboarded corner sequences for uart_rx_frontend
module tb_uart_rx_frontend;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd_in = 1'b1;
  logic rx_ready = 1'b0;
  logic [7:0] rx_data;
  logic rx_valid, frame_err, overrun_err;
`ifdef UART_RX_PARITY_EN
  logic parity_err;
`endif
  int checks = 0;
  int errors = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int vc = 0;
  int fe0, ov0, vc0;
  logic [7:0] exp_q [$];
  typedef struct {
    logic [7:0] data;
    bit stop_ok;
    int exp_fe;
    int exp_vc;
  } vec_t;
  vec_t tbl [6];

  always #5 clk = ~clk;

  uart_rx_frontend #(.CLK_HZ(1600000), .BAUD(100000), .OVERSAMPLE(16), .FIFO_DEPTH(4)) dut (
    .clk(clk),
    .rst(rst),
    .rxd_in(rxd_in),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .frame_err(frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err(parity_err),
`endif
    .overrun_err(overrun_err)
  );

  task automatic chk(input string n, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", n, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit keep);
    if (keep) exp_q.push_back(d);
    rxd_in = 1'b0;
    wait_clk(16);
    for (int i = 0; i < 8; i++) begin
      rxd_in = d[i];
      wait_clk(16);
    end
    if (stop_ok) begin
      rxd_in = 1'b1;
      wait_clk(16);
    end else begin
      rxd_in = 1'b0;
      wait_clk(40);
      rxd_in = 1'b1;
      wait_clk(16);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (rx_valid) vc++;
      if (frame_err) fe_cnt++;
      if (overrun_err) ov_cnt++;
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte got %0h exp none", rx_data);
        end else chk("rx_data", rx_data, exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{8'hA5, 1'b1, 0, 1};
    tbl[1] = '{8'h10, 1'b1, 0, 1};
    tbl[2] = '{8'h00, 1'b1, 0, 1};
    tbl[3] = '{8'hFF, 1'b1, 0, 1};
    tbl[4] = '{8'h55, 1'b0, 1, 0};
    tbl[5] = '{8'h13, 1'b1, 0, 1};
    wait_clk(3);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_rx_data", rx_data, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun_err", overrun_err, 0);
    wait_clk(4);
    rx_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      fe0 = fe_cnt;
      vc0 = vc;
      ov0 = ov_cnt;
      send_frame(tbl[i].data, tbl[i].stop_ok, tbl[i].stop_ok);
      wait_clk(8);
      chk($sformatf("frame_err_pulses[%0d]", i), fe_cnt - fe0, tbl[i].exp_fe);
      chk($sformatf("valid_cycles[%0d]", i), vc - vc0, tbl[i].exp_vc);
      chk($sformatf("overrun_pulses[%0d]", i), ov_cnt - ov0, 0);
      chk($sformatf("queue_drained[%0d]", i), exp_q.size(), 0);
    end
    fe0 = fe_cnt;
    vc0 = vc;
    rxd_in = 1'b0;
    wait_clk(4);
    rxd_in = 1'b1;
    wait_clk(40);
    chk("glitch_frame_err", fe_cnt - fe0, 0);
    chk("glitch_valid_cycles", vc - vc0, 0);
    send_frame(8'h12, 1'b1, 1'b1);
    wait_clk(8);
    chk("after_glitch_valid_cycles", vc - vc0, 1);
    chk("after_glitch_drained", exp_q.size(), 0);
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, i < 5);
    wait_clk(4);
    chk("overrun_pulses", ov_cnt - ov0, 1);
    chk("full_rx_valid", rx_valid, 1);
    rx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("drain_valid[%0d]", i), rx_valid, 1);
    end
    @(negedge clk);
    chk("drain_empty", rx_valid, 0);
    chk("drain_queue", exp_q.size(), 0);
    wait_clk(1);
    rx_ready = 1'b0;
    ov0 = ov_cnt;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 1'b1);
    fork
      send_frame(8'h05, 1'b1, 1'b1);
      begin
        wait_clk(157);
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
      end
    join
    wait_clk(4);
    chk("push_pop_full_overrun", ov_cnt - ov0, 0);
    chk("push_pop_queue_left", exp_q.size(), 4);
    rx_ready = 1'b1;
    wait_clk(8);
    chk("push_pop_drained", exp_q.size(), 0);
    chk("push_pop_empty", rx_valid, 0);
    rx_ready = 1'b0;
    send_frame(8'h21, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b1);
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    fork
      send_frame(8'hFF, 1'b1, 1'b0);
      begin
        wait_clk(70);
        rst = 1'b1;
        exp_q.delete();
        wait_clk(1);
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_rx_valid", rx_valid, 0);
        chk("post_reset_rx_data", rx_data, 0);
      end
    join
    wait_clk(4);
    rx_ready = 1'b1;
    vc0 = vc;
    send_frame(8'h11, 1'b1, 1'b1);
    wait_clk(8);
    chk("post_reset_valid_cycles", vc - vc0, 1);
    chk("post_reset_drained", exp_q.size(), 0);
    chk("post_reset_frame_err", fe_cnt - fe0, 0);
    chk("post_reset_overrun", ov_cnt - ov0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
